sa_pe_fused: RTL and testbench
==============================

# sa_pe_fused

Weight-stationary processing element for rows of the systolic array, successor to the fixed 4-bit PE. Supports a parametrised operand width and three precision modes: one full-width product, two half-width lanes, or four quarter-width lanes per cycle. Adds double-buffered weights (shadow load while computing), valid-qualified dataflow and a two-stage pipeline. One instance per array cell; activations flow right, partial sums flow down.

## Interface
- `DATA_W`, 8: operand width; multiple of 4.
- `ROW_INDEX`, 1: row position (≥1); sets psum growth.
- Derived `SEG_IN` = DATA_W/2 + ROW_INDEX − 1; `SEG_OUT` = SEG_IN + 1.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low.
- `act_in`  in  DATA_W  activation from left.
- `act_valid_in`  in  1  qualifies act_in.
- `act_out`, `act_valid_out`  out  DATA_W, 1  registered pass-through to right.
- `w_load`  in  1  capture act_in into shadow weight and shadow mode.
- `mode_in`  in  2  precision mode captured with w_load.
- `w_swap_in`  in  1  copy shadow → active weight/mode.
- `w_swap_out`  out  1  w_swap_in delayed one cycle, to right neighbour.
- `sx`, `sy`  in  1 each  activation / weight signed when high.
- `psum_in`  in  4·SEG_IN  partial sum from above.
- `psum_valid_in`  in  1  qualifies psum_in.
- `psum_out`  out  4·SEG_OUT  partial sum downward.
- `psum_valid_out`  out  1  qualifies psum_out.
- `err`  out  1  sticky protocol/mode error.

## Operation
- Modes (package enum): MODE_1X=00 (one DATA_W×DATA_W lane), MODE_2X=01 (two DATA_W/2 lanes), MODE_4X=10 (four DATA_W/4 lanes). 11 is illegal: executes as MODE_1X and sets err.
- Lane i uses operand bits [(i+1)·DATA_W/L−1 : i·DATA_W/L], where L is the lane count.
- Psum bus is four segments. In 4X, lane i uses segment i. In 2X, lane i uses segments {2i+1,2i} concatenated. In 1X, all four segments form one field.
- Per lane: out = psum_in_field + product. Sign- or zero-extend per sx|sy. Result width is the input field width plus one bit per segment used, so there is no overflow.
- psum_in is treated as 0 when psum_valid_in is low.
- Weight path:
  - w_load: shadow_w ← act_in, shadow_mode ← mode_in. This does not affect computation.
  - w_swap_in: active_w ← shadow_w, active_mode ← shadow_mode.
  - w_load and w_swap_in in the same cycle: the swap takes the old shadow value and the shadow takes the new value.
- err is set by any of the following, and cleared only by reset:
  - psum_valid_in high while stage-1 is invalid;
  - active mode is 11;
  - w_swap_in while stage-1 is valid and its mode differs from the incoming mode.
- `act_out`/`act_valid_out` update every cycle regardless of w_load. A load word is passed right with act_valid_out = act_valid_in, so the row shifts weights.

## Timing
- Stage 1 (edge t): registers product of act_in × active_w, plus valid and mode. Uses active_w from before any swap sampled at the same edge.
- Stage 2 (edge t+1): psum_out ← stage-1 product + psum_in sampled at edge t+1; psum_valid_out ← stage-1 valid.
- Latency: activation to psum_out is 2 cycles. psum_in must arrive exactly 1 cycle after its activation. The feeder skews activations by 1 cycle per row.
- act_out, act_valid_out and w_swap_out have 1-cycle latency.
- A swap at edge t takes effect for activations sampled at edge t+1 onward.
- Reset (async, any time):
  - act_out, act_valid_out, psum_out, psum_valid_out, w_swap_out and err go to 0;
  - active/shadow weight go to 0; active/shadow mode go to MODE_1X;
  - in-flight data is discarded.

## Structure
- Package `sa_pkg`: `pe_mode_e` enum, lane-count function, SEG width helper functions.
- Sub-module `sa_fused_mult`: combinational DATA_W fused multiplier built from DATA_W/4-bit bricks, with mode/sx/sy inputs. It outputs 4 product segments already aligned to the psum segments.
- Top-level holds the weight registers, the two pipeline stages and the error logic.

## Test plan
- MODE_1X unsigned, DATA_W=8, ROW_INDEX=1: load 0x0F, swap; act 0x10; psum_in 0x0005 one cycle later → psum_out 0x000F5 two cycles after act, valid for 1 cycle.
- MODE_4X signed: weight 8'b11_01_10_01, act 8'b01_01_01_11, psum_in 0 → segments {5'h1F, 5'h01, 5'h1E, 5'h1F}.
- Double buffer: active 0x02, stream act 0x05 each cycle. Load 0x03, then swap at edge k → products 10 through act sampled at k, 15 from k+1, with no bubble.
- Load and swap in the same cycle: shadow 0x04, then load 0x07 + swap together → active 0x04; a later swap → active 0x07.
- Reset pulse while psum_valid_out=1 → all outputs 0 immediately; after release, no valid output until a new act_valid_in.
- Mode 11 swapped in → err=1, result equals MODE_1X; err stays high until reset.
- psum_valid_in high with no prior act → err=1, psum_valid_out stays 0.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and width helpers for the fused weight-stationary PE.
package sa_pkg;

  typedef enum logic [1:0] {
    MODE_1X  = 2'b00,
    MODE_2X  = 2'b01,
    MODE_4X  = 2'b10,
    MODE_ILL = 2'b11
  } pe_mode_e;

  // The illegal encoding runs as a single full-width lane.
  function automatic int lane_cnt(pe_mode_e m);
    case (m)
      MODE_2X: return 2;
      MODE_4X: return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int seg_in_w(int data_w, int row);
    return data_w / 2 + row - 1;
  endfunction

  function automatic int seg_out_w(int data_w, int row);
    return seg_in_w(data_w, row) + 1;
  endfunction

endpackage

// File: rtl/sa_pe_fused_if.sv
// PE-to-PE bus: activation/weight path in, registered copies out, psum in/out.
interface sa_pe_fused_if #(
  parameter int DATA_W    = 8,
  parameter int ROW_INDEX = 1
);
  import sa_pkg::*;
  localparam int SEG_IN  = seg_in_w(DATA_W, ROW_INDEX);
  localparam int SEG_OUT = seg_out_w(DATA_W, ROW_INDEX);

  logic [DATA_W-1:0]    act_in;
  logic                 act_valid_in;
  logic [DATA_W-1:0]    act_out;
  logic                 act_valid_out;
  logic                 w_load;
  logic [1:0]           mode_in;
  logic                 w_swap_in;
  logic                 w_swap_out;
  logic                 sx;
  logic                 sy;
  logic [4*SEG_IN-1:0]  psum_in;
  logic                 psum_valid_in;
  logic [4*SEG_OUT-1:0] psum_out;
  logic                 psum_valid_out;
  logic                 err;

  modport master (
    output act_in, act_valid_in, w_load, mode_in, w_swap_in, sx, sy,
           psum_in, psum_valid_in,
    input  act_out, act_valid_out, w_swap_out, psum_out, psum_valid_out, err
  );

  modport slave (
    input  act_in, act_valid_in, w_load, mode_in, w_swap_in, sx, sy,
           psum_in, psum_valid_in,
    output act_out, act_valid_out, w_swap_out, psum_out, psum_valid_out, err
  );
endinterface

// File: rtl/sa_fused_mult.sv
// Combinational multiplier from DATA_W/4-bit signed bricks, regrouped per precision
// mode; each lane product is fully extended and placed on its psum segments.
module sa_fused_mult import sa_pkg::*; #(
  parameter int DATA_W  = 8,
  parameter int SEG_OUT = 5
) (
  input  logic [DATA_W-1:0]        a_i,
  input  logic [DATA_W-1:0]        b_i,
  input  pe_mode_e                 mode_i,
  input  logic                     sx_i,
  input  logic                     sy_i,
  output logic [3:0][SEG_OUT-1:0]  prod_o
);
  localparam int Q  = DATA_W / 4;
  localparam int PW = 4 * SEG_OUT;

  int                  lanes;
  logic [1:0]          lane_of [4];
  logic [1:0]          off     [4];
  logic [3:0]          top;
  logic signed [Q:0]   ax [4];
  logic signed [Q:0]   bx [4];
  logic signed [2*Q+1:0] pp;
  logic signed [PW-1:0]  t;
  logic signed [PW-1:0]  lane_p [4];

  always_comb begin
    lanes = lane_cnt(mode_i);
    for (int j = 0; j < 4; j++) lane_of[j] = 2'((j * lanes) >> 2);
    off[0] = 2'd0;
    for (int j = 1; j < 4; j++)
      off[j] = (lane_of[j] == lane_of[j-1]) ? off[j-1] + 2'd1 : 2'd0;
    for (int j = 0; j < 3; j++) top[j] = lane_of[j+1] != lane_of[j];
    top[3] = 1'b1;
    // Only the top quarter of a signed lane carries a sign; lower quarters are magnitude.
    for (int j = 0; j < 4; j++) begin
      ax[j] = {sx_i & top[j] & a_i[j*Q+Q-1], a_i[j*Q +: Q]};
      bx[j] = {sy_i & top[j] & b_i[j*Q+Q-1], b_i[j*Q +: Q]};
    end
    pp = '0;
    t  = '0;
    for (int l = 0; l < 4; l++) lane_p[l] = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (lane_of[i] == lane_of[j]) begin
          pp = ax[i] * bx[j];
          t  = pp;
          lane_p[lane_of[i]] = lane_p[lane_of[i]] + (t <<< (Q * (int'(off[i]) + int'(off[j]))));
        end
  end

  always_comb begin
    prod_o = '0;
    case (mode_i)
      MODE_4X: for (int l = 0; l < 4; l++) prod_o[l] = lane_p[l][SEG_OUT-1:0];
      MODE_2X: for (int h = 0; h < 2; h++)
                 {prod_o[2*h+1], prod_o[2*h]} = lane_p[h][2*SEG_OUT-1:0];
      default: prod_o = lane_p[0];
    endcase
  end
endmodule

// File: rtl/sa_pe_fused.sv
// Weight-stationary PE: double-buffered weight/mode, product stage, psum-add stage,
// sticky protocol error.
module sa_pe_fused import sa_pkg::*; #(
  parameter int DATA_W    = 8,
  parameter int ROW_INDEX = 1
) (
  input  logic          clk,
  input  logic          reset,
  sa_pe_fused_if.slave  pe
);
  localparam int SEG_IN  = seg_in_w(DATA_W, ROW_INDEX);
  localparam int SEG_OUT = seg_out_w(DATA_W, ROW_INDEX);

  typedef struct packed {
    pe_mode_e                mode;
    logic                    sgn;
    logic [3:0][SEG_OUT-1:0] prod;
  } s1_t;

  logic [DATA_W-1:0]       act_q, shw_q, actw_q;
  pe_mode_e                shm_q, actm_q;
  logic                    avld_q, swp_q, err_q, err_d;
  logic [1:0]              vld_pipe_q;
  s1_t                     s1_q, s1_d;
  logic [3:0][SEG_OUT-1:0] prod, sum_d, psum_q;
  logic [3:0][SEG_IN-1:0]  pin;

  sa_fused_mult #(.DATA_W(DATA_W), .SEG_OUT(SEG_OUT)) u_mult (
    .a_i(pe.act_in), .b_i(actw_q), .mode_i(actm_q),
    .sx_i(pe.sx), .sy_i(pe.sy), .prod_o(prod)
  );

  assign pin = pe.psum_valid_in ? pe.psum_in : '0;

  always_comb begin
    s1_d.mode = actm_q;
    s1_d.sgn  = pe.sx | pe.sy;
    s1_d.prod = prod;
  end

  // Psum fields are widened by one bit per segment they span.
  always_comb begin
    sum_d = '0;
    case (s1_q.mode)
      MODE_4X: for (int l = 0; l < 4; l++)
                 sum_d[l] = s1_q.prod[l] + {s1_q.sgn & pin[l][SEG_IN-1], pin[l]};
      MODE_2X: for (int h = 0; h < 2; h++)
                 {sum_d[2*h+1], sum_d[2*h]} = {s1_q.prod[2*h+1], s1_q.prod[2*h]}
                   + {{2{s1_q.sgn & pin[2*h+1][SEG_IN-1]}}, pin[2*h+1], pin[2*h]};
      default: sum_d = s1_q.prod + {{4{s1_q.sgn & pin[3][SEG_IN-1]}}, pin};
    endcase
  end

  always_comb begin
    err_d = err_q
          | (pe.psum_valid_in & ~vld_pipe_q[0])
          | (actm_q == MODE_ILL)
          | (pe.w_swap_in & vld_pipe_q[0] & (s1_q.mode != shm_q));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_q      <= '0;
      avld_q     <= 1'b0;
      swp_q      <= 1'b0;
      vld_pipe_q <= '0;
      s1_q       <= '0;
      psum_q     <= '0;
      err_q      <= 1'b0;
      shw_q      <= '0;
      actw_q     <= '0;
      shm_q      <= MODE_1X;
      actm_q     <= MODE_1X;
    end else begin
      act_q      <= pe.act_in;
      avld_q     <= pe.act_valid_in;
      swp_q      <= pe.w_swap_in;
      vld_pipe_q <= {vld_pipe_q[0], pe.act_valid_in};
      s1_q       <= s1_d;
      err_q      <= err_d;
      if (vld_pipe_q[0]) psum_q <= sum_d;
      // Swap reads the shadow before a same-cycle load overwrites it.
      if (pe.w_swap_in) begin
        actw_q <= shw_q;
        actm_q <= shm_q;
      end
      if (pe.w_load) begin
        shw_q <= pe.act_in;
        shm_q <= pe_mode_e'(pe.mode_in);
      end
    end
  end

  assign pe.act_out        = act_q;
  assign pe.act_valid_out  = avld_q;
  assign pe.w_swap_out     = swp_q;
  assign pe.psum_out       = psum_q;
  assign pe.psum_valid_out = vld_pipe_q[1];
  assign pe.err            = err_q;
endmodule

// File: tb/tb_sa_pe_fused.sv
// Bench for sa_pe_fused (DATA_W=8, ROW_INDEX=1): directed scenarios plus random
// traffic against a lane-arithmetic reference model.
module tb_sa_pe_fused;
  localparam int W  = 8;
  localparam int SI = 4;
  localparam int SO = 5;

  logic clk, reset;
  int   n_chk, n_err;

  sa_pe_fused_if #(.DATA_W(W), .ROW_INDEX(1)) bus ();
  sa_pe_fused #(.DATA_W(W), .ROW_INDEX(1)) dut (.clk(clk), .reset(reset), .pe(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference state
  logic [7:0]  m_sw, m_aw, m_a1, m_w1, e_ao;
  logic [1:0]  m_sm, m_am, m_m1;
  logic        m_v1, m_sx1, m_sy1, e_avo, e_swo, e_pvo, e_err;
  logic [19:0] e_ps;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] ref_psum(input logic [7:0] a, input logic [7:0] w,
                                           input logic [1:0] md, input logic sa, input logic sb,
                                           input logic [15:0] p);
    int L, n, fi, fo;
    longint av, bv, pv, r, res;
    L  = (md == 2'b01) ? 2 : (md == 2'b10) ? 4 : 1;
    n  = W / L;
    fi = 4 * SI / L;
    fo = 4 * SO / L;
    res = 0;
    for (int l = 0; l < L; l++) begin
      av = (longint'(a) >> (l*n)) & ((longint'(1) << n) - 1);
      bv = (longint'(w) >> (l*n)) & ((longint'(1) << n) - 1);
      pv = (longint'(p) >> (l*fi)) & ((longint'(1) << fi) - 1);
      if (sa && av[n-1]) av -= longint'(1) << n;
      if (sb && bv[n-1]) bv -= longint'(1) << n;
      if ((sa || sb) && pv[fi-1]) pv -= longint'(1) << fi;
      r = pv + av * bv;
      res |= (r & ((longint'(1) << fo) - 1)) << (l*fo);
    end
    return res[19:0];
  endfunction

  task automatic m_reset();
    m_sw = '0; m_aw = '0; m_a1 = '0; m_w1 = '0; e_ao = '0;
    m_sm = '0; m_am = '0; m_m1 = '0;
    m_v1 = 0; m_sx1 = 0; m_sy1 = 0; e_avo = 0; e_swo = 0; e_pvo = 0; e_err = 0;
    e_ps = '0;
  endtask

  task automatic idle_in();
    bus.act_in = '0; bus.act_valid_in = 0; bus.w_load = 0; bus.mode_in = '0;
    bus.w_swap_in = 0; bus.sx = 0; bus.sy = 0; bus.psum_in = '0; bus.psum_valid_in = 0;
  endtask

  task automatic check_outs();
    chk("act_out", bus.act_out, e_ao);
    chk("act_vld", bus.act_valid_out, e_avo);
    chk("swap_out", bus.w_swap_out, e_swo);
    chk("psum_vld", bus.psum_valid_out, e_pvo);
    chk("err", bus.err, e_err);
    if (e_pvo) chk("psum", bus.psum_out, e_ps);
  endtask

  // One clock: drive, advance the reference at the edge, check at the falling edge.
  task automatic step(input logic [7:0] a, input logic av, input logic wl, input logic [1:0] md,
                      input logic ws, input logic sa, input logic sb,
                      input logic [15:0] ps, input logic pv);
    bus.act_in = a; bus.act_valid_in = av; bus.w_load = wl; bus.mode_in = md;
    bus.w_swap_in = ws; bus.sx = sa; bus.sy = sb; bus.psum_in = ps; bus.psum_valid_in = pv;
    @(posedge clk);
    e_err = e_err | (pv & ~m_v1) | (m_am == 2'b11) | (ws & m_v1 & (m_m1 != m_sm));
    e_pvo = m_v1;
    if (m_v1) e_ps = ref_psum(m_a1, m_w1, m_m1, m_sx1, m_sy1, pv ? ps : 16'h0);
    e_ao = a; e_avo = av; e_swo = ws;
    m_v1 = av; m_a1 = a; m_w1 = m_aw; m_m1 = m_am; m_sx1 = sa; m_sy1 = sb;
    if (ws) begin m_aw = m_sw; m_am = m_sm; end
    if (wl) begin m_sw = a; m_sm = md; end
    @(negedge clk);
    check_outs();
  endtask

  task automatic do_reset();
    idle_in();
    reset = 0;
    m_reset();
    #1;
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    idle_in();
    reset = 0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_psum", bus.psum_out, 20'h0);
    chk("rst_err", bus.err, 1'b0);
    check_outs();
    reset = 1;

    // 1X unsigned: 0x0F * 0x10 + 5
    step(8'h0F, 0, 1, 2'b00, 0, 0, 0, 16'h0, 0);
    step(8'h00, 0, 0, 2'b00, 1, 0, 0, 16'h0, 0);
    step(8'h10, 1, 0, 2'b00, 0, 0, 0, 16'h0, 0);
    step(8'h00, 0, 0, 2'b00, 0, 0, 0, 16'h0005, 1);
    chk("A_psum", bus.psum_out, 20'h000F5);
    chk("A_vld", bus.psum_valid_out, 1'b1);
    step(8'h00, 0, 0, 2'b00, 0, 0, 0, 16'h0, 0);
    chk("A_vld_drop", bus.psum_valid_out, 1'b0);

    // 4X signed
    step(8'b11_01_10_01, 0, 1, 2'b10, 0, 0, 0, 16'h0, 0);
    step(8'h00, 0, 0, 2'b00, 1, 0, 0, 16'h0, 0);
    step(8'b01_01_01_11, 1, 0, 2'b00, 0, 1, 1, 16'h0, 0);
    step(8'h00, 0, 0, 2'b00, 0, 1, 1, 16'h0, 1);
    chk("B_psum", bus.psum_out, {5'h1F, 5'h01, 5'h1E, 5'h1F});

    // double buffer: 2 -> 3 swapped mid-stream at stream step 2
    step(8'h02, 0, 1, 2'b00, 0, 0, 0, 16'h0, 0);
    step(8'h00, 0, 0, 2'b00, 1, 0, 0, 16'h0, 0);
    step(8'h03, 0, 1, 2'b00, 0, 0, 0, 16'h0, 0);
    for (int i = 0; i < 6; i++) begin
      step(8'h05, 1, 0, 2'b00, i == 2, 0, 0, 16'h0, i > 0);
      if (i > 0) chk("DB_prod", bus.psum_out, (i <= 3) ? 20'd10 : 20'd15);
    end
    step(8'h00, 0, 0, 2'b00, 0, 0, 0, 16'h0, 1);
    chk("DB_last", bus.psum_out, 20'd15);

    // load + swap in the same cycle
    step(8'h04, 0, 1, 2'b00, 0, 0, 0, 16'h0, 0);
    step(8'h07, 0, 1, 2'b00, 1, 0, 0, 16'h0, 0);
    step(8'h01, 1, 0, 2'b00, 0, 0, 0, 16'h0, 0);
    step(8'h00, 0, 0, 2'b00, 0, 0, 0, 16'h0, 1);
    chk("LS_old", bus.psum_out, 20'd4);
    step(8'h00, 0, 0, 2'b00, 1, 0, 0, 16'h0, 0);
    step(8'h01, 1, 0, 2'b00, 0, 0, 0, 16'h0, 0);
    step(8'h00, 0, 0, 2'b00, 0, 0, 0, 16'h0, 1);
    chk("LS_new", bus.psum_out, 20'd7);

    // async reset while a result is valid
    step(8'h03, 1, 0, 2'b00, 0, 0, 0, 16'h0, 0);
    step(8'h00, 0, 0, 2'b00, 0, 0, 0, 16'h0, 1);
    chk("R_pre_vld", bus.psum_valid_out, 1'b1);
    idle_in();
    reset = 0;
    #1;
    chk("R_psum", bus.psum_out, 20'h0);
    chk("R_vld", bus.psum_valid_out, 1'b0);
    chk("R_act", bus.act_out, 8'h0);
    chk("R_avld", bus.act_valid_out, 1'b0);
    m_reset();
    @(negedge clk);
    reset = 1;
    repeat (2) step(8'h00, 0, 0, 2'b00, 0, 0, 0, 16'h0, 0);
    chk("R_no_vld", bus.psum_valid_out, 1'b0);

    // illegal mode runs as 1X and latches err
    step(8'h03, 0, 1, 2'b11, 0, 0, 0, 16'h0, 0);
    step(8'h00, 0, 0, 2'b00, 1, 0, 0, 16'h0, 0);
    step(8'h05, 1, 0, 2'b00, 0, 0, 0, 16'h0, 0);
    step(8'h00, 0, 0, 2'b00, 0, 0, 0, 16'h0, 1);
    chk("M3_err", bus.err, 1'b1);
    chk("M3_psum", bus.psum_out, 20'd15);
    step(8'h00, 0, 1, 2'b00, 1, 0, 0, 16'h0, 0);
    repeat (3) step(8'h00, 0, 0, 2'b00, 0, 0, 0, 16'h0, 0);
    chk("M3_sticky", bus.err, 1'b1);
    do_reset();
    chk("M3_clear", bus.err, 1'b0);

    // psum without a matching activation
    step(8'h00, 0, 0, 2'b00, 0, 0, 0, 16'h1234, 1);
    chk("PV_err", bus.err, 1'b1);
    step(8'h00, 0, 0, 2'b00, 0, 0, 0, 16'h0, 0);
    chk("PV_novld", bus.psum_valid_out, 1'b0);
    do_reset();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      logic [7:0]  ra;
      logic [1:0]  rm;
      logic [15:0] rp;
      ra = 8'($urandom);
      rm = 2'($urandom_range(0, 2));
      rp = 16'($urandom);
      step(ra, 1'($urandom), ($urandom_range(0, 7) == 0), rm,
           ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom), rp, m_v1);
      if (c == 200) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
